// File: rtl/controle_execucao_if.sv
// Bus between the decoder/datapath side and the execution sequencer:
// decoded flags, user I/O values and the PC/register-file strobes.
interface controle_execucao_if #(
  parameter int LARGURA_CHAVES = 16
);
  logic                      OpIn;
  logic                      OpOut;
  logic                      OpHalt;
  logic                      confirma;
  logic [LARGURA_CHAVES-1:0] chaves;
  logic [31:0]               dado_out;
  logic                      HabilitaPC;
  logic                      EscreveIn;
  logic [31:0]               dado_in;
  logic [31:0]               display;
  logic                      aguardando_in;
  logic                      parado;

  modport master (
    output OpIn, OpOut, OpHalt, confirma, chaves, dado_out,
    input  HabilitaPC, EscreveIn, dado_in, display, aguardando_in, parado
  );

  modport slave (
    input  OpIn, OpOut, OpHalt, confirma, chaves, dado_out,
    output HabilitaPC, EscreveIn, dado_in, display, aguardando_in, parado
  );
endinterface

// File: rtl/controle_execucao.sv
// Multi-cycle sequencer turning the decoded in/out/halt flags into PC stalls,
// with a synchronized and debounced confirm button for the `in` instruction.
module controle_execucao #(
  parameter int LARGURA_CHAVES = 16,
  parameter int DEBOUNCE       = 4,
  parameter int HOLD_OUT       = 3
) (
  input  logic               clock,
  input  logic               reset,
  controle_execucao_if.slave bus
);

  localparam logic [2:0] EXECUTA       = 3'd0;
  localparam logic [2:0] ESPERA_SOLTAR = 3'd1;
  localparam logic [2:0] ESPERA_IN     = 3'd2;
  localparam logic [2:0] CAPTURA       = 3'd3;
  localparam logic [2:0] MOSTRA        = 3'd4;
  localparam logic [2:0] PARADO        = 3'd5;

  localparam int SYNC_STAGES = 2;
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int CNT_W = (HOLD_OUT > 1) ? $clog2(HOLD_OUT) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] HOLD_INI = CNT_W'(HOLD_OUT - 1);

  logic [SYNC_STAGES-1:0]    sync_reg;
  logic [SYNC_STAGES-1:0]    sync_next;
  logic [DEB_W-1:0]          deb_cnt_reg;
  logic [DEB_W-1:0]          deb_cnt_next;
  logic                      estavel_reg;
  logic                      estavel_next;
  logic [2:0]                state_reg;
  logic [2:0]                state_next;
  logic [CNT_W-1:0]          contador_reg;
  logic [CNT_W-1:0]          contador_next;
  logic [31:0]               dado_in_reg;
  logic [31:0]               dado_in_next;
  logic [31:0]               display_reg;
  logic [31:0]               display_next;
  logic                      hab_pc;
  logic                      escreve;
  logic                      sync_out;
  logic [LARGURA_CHAVES-1:0] chaves_w;

  assign chaves_w = bus.chaves;
  assign sync_out = sync_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_in
        assign sync_next[gi] = bus.confirma;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // The stable level only flips after DEBOUNCE consecutive cycles of disagreement;
  // any cycle of agreement drops the count back to zero.
  always_comb begin
    deb_cnt_next = '0;
    estavel_next = estavel_reg;
    if (sync_out != estavel_reg) begin
      if (deb_cnt_reg == DEB_MAX) begin
        estavel_next = sync_out;
      end else begin
        deb_cnt_next = deb_cnt_reg + DEB_W'(1);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    contador_next = contador_reg;
    dado_in_next  = dado_in_reg;
    display_next  = display_reg;
    hab_pc        = 1'b0;
    escreve       = 1'b0;
    case (state_reg)
      EXECUTA: begin
        if (bus.OpHalt) begin
          state_next = PARADO;
        end else if (bus.OpIn) begin
          state_next = ESPERA_SOLTAR;
        end else if (bus.OpOut) begin
          state_next    = MOSTRA;
          display_next  = bus.dado_out;
          contador_next = HOLD_INI;
        end else begin
          hab_pc = 1'b1;
        end
      end
      // A button still held from the previous `in` must be released first.
      ESPERA_SOLTAR: begin
        if (!estavel_reg) begin
          state_next = ESPERA_IN;
        end
      end
      ESPERA_IN: begin
        if (estavel_reg) begin
          state_next   = CAPTURA;
          dado_in_next = 32'(chaves_w);
        end
      end
      CAPTURA: begin
        hab_pc     = 1'b1;
        escreve    = 1'b1;
        state_next = EXECUTA;
      end
      MOSTRA: begin
        if (contador_reg == '0) begin
          hab_pc     = 1'b1;
          state_next = EXECUTA;
        end else begin
          contador_next = contador_reg - CNT_W'(1);
        end
      end
      PARADO: begin
        state_next = PARADO;
      end
      default: begin
        state_next = EXECUTA;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_reg     <= '0;
      deb_cnt_reg  <= '0;
      estavel_reg  <= 1'b0;
      state_reg    <= EXECUTA;
      contador_reg <= '0;
      dado_in_reg  <= '0;
      display_reg  <= '0;
    end else begin
      sync_reg     <= sync_next;
      deb_cnt_reg  <= deb_cnt_next;
      estavel_reg  <= estavel_next;
      state_reg    <= state_next;
      contador_reg <= contador_next;
      dado_in_reg  <= dado_in_next;
      display_reg  <= display_next;
    end
  end

  // Everything is held at zero while reset is low, including the registered values.
  assign bus.HabilitaPC    = reset & hab_pc;
  assign bus.EscreveIn     = reset & escreve;
  assign bus.aguardando_in = reset & ((state_reg == ESPERA_SOLTAR) || (state_reg == ESPERA_IN));
  assign bus.parado        = reset & (state_reg == PARADO);
  assign bus.dado_in       = reset ? dado_in_reg : '0;
  assign bus.display       = reset ? display_reg : '0;

endmodule

// File: tb/tb_controle_execucao.sv
// Scoreboarded bench: a driver issues instructions and pushes expectations,
// a negedge monitor derives per-cycle outputs from an instruction-level model.
module tb_controle_execucao;
  localparam int LC   = 16;
  localparam int DEB  = 4;
  localparam int HOLD = 3;
  localparam int K_PLAIN = 0, K_OUT = 1, K_IN = 2, K_HALT = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  controle_execucao_if #(.LARGURA_CHAVES(LC)) bus ();

  controle_execucao #(
    .LARGURA_CHAVES(LC),
    .DEBOUNCE(DEB),
    .HOLD_OUT(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial forever #5 clock = ~clock;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   ncyc = 0;
  int   btn_mode = 0;

  function automatic string kname(input int k);
    case (k)
      K_PLAIN: return "plain";
      K_OUT:   return "out";
      K_IN:    return "in";
      default: return "halt";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, ncyc, act, req);
    end
  endtask

  // Button: forced low/high, or random press/release segments (short ones are glitches).
  initial begin : button
    bit lvl;
    int seg;
    lvl = 1'b0;
    seg = 0;
    bus.confirma = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (btn_mode)
        0: bus.confirma = 1'b0;
        1: bus.confirma = 1'b1;
        default: begin
          if (seg == 0) begin
            lvl = ~lvl;
            seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 14);
          end
          seg--;
          bus.confirma = lvl;
        end
      endcase
    end
  end

  // Monitor: stable button level from a sliding window of raw samples, then
  // the expected outputs of the instruction in progress.
  initial begin : monitor
    bit          raw_eff [0:63];
    bit          stab, rst_prev, active, allv, v, fin;
    bit          e_hab, e_wr, e_wt, e_par;
    int          last_rst, cur_start, phase;
    exp_t        cur;
    logic [31:0] mdisp, mdin;
    stab = 0; rst_prev = 0; active = 0; last_rst = 0; cur_start = 0; phase = 0;
    mdisp = '0; mdin = '0;
    for (int j = 0; j < 64; j++) raw_eff[j] = 1'b0;
    forever begin
      @(negedge clock);
      ncyc++;
      raw_eff[ncyc % 64] = bus.confirma;
      if (rst_prev) begin
        stab = 1'b0;
      end else if (ncyc - DEB > last_rst) begin
        v = raw_eff[(ncyc - 2 - DEB) % 64];
        allv = 1'b1;
        for (int j = ncyc - 2 - DEB; j <= ncyc - 3; j++)
          if (raw_eff[j % 64] != v) allv = 1'b0;
        if (allv && v != stab) stab = v;
      end
      if (!reset) begin
        chk("rst_habilita_pc", 32'(bus.HabilitaPC), 32'd0);
        chk("rst_escreve_in", 32'(bus.EscreveIn), 32'd0);
        chk("rst_aguardando", 32'(bus.aguardando_in), 32'd0);
        chk("rst_parado", 32'(bus.parado), 32'd0);
        chk("rst_display", bus.display, 32'd0);
        chk("rst_dado_in", bus.dado_in, 32'd0);
        last_rst = ncyc;
        raw_eff[ncyc % 64] = 1'b0;
        raw_eff[(ncyc - 1) % 64] = 1'b0;
        stab = 1'b0;
        mdisp = '0;
        mdin = '0;
        if (active) $display("cycle %0d: reset aborts %s", ncyc, kname(cur.kind));
        active = 1'b0;
        exp_q.delete();
        rst_prev = 1'b1;
      end else begin
        rst_prev = 1'b0;
        if (!active && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          active = 1'b1;
          cur_start = ncyc;
          phase = 0;
        end
        e_hab = 0; e_wr = 0; e_wt = 0; e_par = 0; fin = 0;
        if (!active) begin
          e_hab = 1'b1;
        end else begin
          case (cur.kind)
            K_PLAIN: begin e_hab = 1'b1; fin = 1'b1; end
            K_OUT: begin
              if (ncyc - cur_start == 1) mdisp = cur.data;
              if (ncyc - cur_start == HOLD) begin e_hab = 1'b1; fin = 1'b1; end
            end
            K_HALT: e_par = (ncyc > cur_start);
            default: begin
              if (ncyc > cur_start) begin
                if (phase == 2) begin
                  e_hab = 1'b1; e_wr = 1'b1; mdin = cur.data; fin = 1'b1;
                end else begin
                  e_wt = 1'b1;
                  if (phase == 0 && !stab) phase = 1;
                  else if (phase == 1 && stab) phase = 2;
                end
              end
            end
          endcase
        end
        chk("habilita_pc", 32'(bus.HabilitaPC), 32'(e_hab));
        chk("escreve_in", 32'(bus.EscreveIn), 32'(e_wr));
        chk("aguardando_in", 32'(bus.aguardando_in), 32'(e_wt));
        chk("parado", 32'(bus.parado), 32'(e_par));
        chk("display", bus.display, mdisp);
        chk("dado_in", bus.dado_in, mdin);
        if (fin) begin
          $display("cycle %0d: %s data=%h done after %0d cycles", ncyc, kname(cur.kind),
                   cur.data, ncyc - cur_start + 1);
          active = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  task automatic clear_flags();
    bus.OpIn = 1'b0;
    bus.OpOut = 1'b0;
    bus.OpHalt = 1'b0;
  endtask

  task automatic issue(input int kind, input logic [31:0] data);
    exp_t e;
    clear_flags();
    bus.chaves = LC'($urandom);
    bus.dado_out = $urandom;
    case (kind)
      K_OUT: begin bus.OpOut = 1'b1; bus.dado_out = data; end
      K_IN: begin
        bus.OpIn = 1'b1;
        bus.OpOut = 1'($urandom_range(0, 1));
        bus.chaves = data[LC-1:0];
      end
      K_HALT: begin
        bus.OpHalt = 1'b1;
        bus.OpIn = 1'b1;
        bus.OpOut = 1'($urandom_range(0, 1));
      end
      default: ;
    endcase
    e.kind = kind;
    e.data = (kind == K_IN) ? 32'(data[LC-1:0]) : data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b0;
    clear_flags();
    repeat (cyc) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_done();
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clock);
      #1;
      k++;
    end
    checks++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL completion_timeout cycle %0d: got no HabilitaPC expected completion", ncyc);
      @(posedge clock);
      #1;
      do_reset(1);
    end else begin
      @(posedge clock);
      #1;
      clear_flags();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int r;
    int kind;
    clear_flags();
    bus.chaves = '0;
    bus.dado_out = '0;
    @(posedge clock);
    #1;
    do_reset(3);

    for (int i = 0; i < 5; i++) begin
      issue(K_PLAIN, 32'd0);
      wait_done();
    end

    issue(K_OUT, 32'h0000_00A5);
    wait_done();

    fork
      begin issue(K_IN, 32'h1234); wait_done(); end
      begin wait_cycles(4); btn_mode = 1; wait_cycles(10); btn_mode = 0; end
    join
    wait_cycles(10);

    // Two-cycle glitch while waiting, then a real press.
    fork
      begin issue(K_IN, 32'hBEEF); wait_done(); end
      begin
        wait_cycles(5); btn_mode = 1; wait_cycles(2); btn_mode = 0;
        wait_cycles(12); btn_mode = 1; wait_cycles(9); btn_mode = 0;
      end
    join
    wait_cycles(10);

    // Back-to-back `in` with the button held across both.
    fork
      begin
        issue(K_IN, 32'h0055); wait_done();
        issue(K_IN, 32'h00AA); wait_done();
      end
      begin
        wait_cycles(3); btn_mode = 1; wait_cycles(40); btn_mode = 0;
        wait_cycles(15); btn_mode = 1; wait_cycles(15); btn_mode = 0;
      end
    join
    wait_cycles(8);

    issue(K_HALT, 32'd0);
    wait_cycles(20);
    do_reset(1);
    issue(K_PLAIN, 32'd0);
    wait_done();

    issue(K_OUT, 32'hDEAD_BEEF);
    wait_cycles(2);
    do_reset(1);
    wait_cycles(2);

    issue(K_IN, 32'h7777);
    wait_cycles(6);
    do_reset(1);
    wait_cycles(3);

    btn_mode = 2;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 5);
      kind = (r < 2) ? K_PLAIN : ((r < 4) ? K_OUT : K_IN);
      issue(kind, $urandom);
      wait_done();
    end

    wait_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/controle_execucao.md
# controle_execucao

Multi-cycle sequencer that sits between the instruction decoder and the program counter of the single-cycle processor. It converts the decoded `OpIn`, `OpOut` and `OpHalt` flags into PC stalls.

- `in` waits for a debounced user confirm button and captures the switch value.
- `out` latches the display register and holds the PC for a fixed display time.
- `halt` freezes the PC until reset.

Every other instruction advances the PC every cycle.

## Interface
Parameters:
- LARGURA_CHAVES, 16: width of the switch input; zero-extended to 32 bits.
- DEBOUNCE, 4: consecutive stable cycles required to accept a new confirm level (≥1).
- HOLD_OUT, 3: extra stall cycles after an `out` (≥1).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising edge of clock).
- OpIn  in  1  decoder flag: current instruction is `in`.
- OpOut  in  1  decoder flag: current instruction is `out`.
- OpHalt  in  1  decoder flag: current instruction is `halt`.
- confirma  in  1  raw, asynchronous confirm button, active-high.
- chaves  in  LARGURA_CHAVES  switch value for `in`.
- dado_out  in  32  register-file read data for `out`.
- HabilitaPC  out  1  PC load enable (combinational from state and flags).
- EscreveIn  out  1  one-cycle write strobe for the `in` destination register; gates EscreveReg.
- dado_in  out  32  registered, zero-extended captured switch value.
- display  out  32  registered display value.
- aguardando_in  out  1  high while waiting for the user (LED).
- parado  out  1  high in PARADO.

## Operation
- Confirm-button path:
  - `confirma` passes through a 2-FF synchronizer.
  - `confirma_estavel` takes the synchronized level only after that level has differed from `confirma_estavel` for DEBOUNCE consecutive cycles.
  - Any glitch resets the debounce counter to 0.
- States: EXECUTA, ESPERA_SOLTAR, ESPERA_IN, CAPTURA, MOSTRA, PARADO.
- EXECUTA, flag priority is Halt > In > Out:
  - OpHalt → PARADO.
  - OpIn → ESPERA_SOLTAR.
  - OpOut → MOSTRA; `display` ← `dado_out`; contador ← HOLD_OUT-1.
  - No flag → stay in EXECUTA.
- ESPERA_SOLTAR: go to ESPERA_IN when confirma_estavel=0. This requires a fresh press for each `in`.
- ESPERA_IN: when confirma_estavel=1, go to CAPTURA and load `dado_in` ← {zeros, chaves}.
- CAPTURA: one cycle, then EXECUTA.
- MOSTRA: decrement contador each cycle; go to EXECUTA in the cycle where contador=0.
- PARADO: terminal; only reset exits it.
- HabilitaPC is 1 in exactly these cases; 0 in all other cases:
  - EXECUTA with no flag set;
  - CAPTURA;
  - MOSTRA with contador=0.
- EscreveIn=1 only in CAPTURA.
- aguardando_in=1 in ESPERA_SOLTAR and ESPERA_IN.
- Flags are ignored outside EXECUTA; the PC is frozen there, so the opcode is stable.

## Timing
- Reset (reset=0 at an edge):
  - state ← EXECUTA.
  - dado_in, display, contador, debounce counter, synchronizer FFs and confirma_estavel ← 0.
  - All outputs are 0 during the reset cycle (HabilitaPC forced 0).
- Reset in any state, including PARADO, MOSTRA or a wait state, aborts the operation with no EscreveIn pulse.
- Plain instruction: HabilitaPC=1 in the same cycle (0 stall).
- `out` at cycle 0:
  - HabilitaPC=0 in cycles 0..HOLD_OUT-1 and 1 in cycle HOLD_OUT; the instruction occupies HOLD_OUT+1 cycles.
  - `display` is visible from cycle 1.
- `in`, confirm already released and debounced:
  - ESPERA_SOLTAR lasts 1 cycle.
  - Raw press → confirma_estavel=1 after 2+DEBOUNCE cycles.
  - CAPTURA is on the following cycle, with EscreveIn=HabilitaPC=1.
  - `dado_in` is valid in CAPTURA.
- `in` with the button held from a previous `in`: stays in ESPERA_SOLTAR until the debounced release.
- `halt`: HabilitaPC=0 from the cycle OpHalt is seen; parado=1 from the next cycle.
- OpIn and OpOut both set: treated as `in`. OpHalt with anything else: treated as `halt`.

## Test plan
- Reset then plain instructions (all flags 0) for 5 cycles → HabilitaPC=1 each cycle; display=0, dado_in=0, parado=0.
- OpOut=1 with dado_out=0x0000_00A5, HOLD_OUT=3 → HabilitaPC 0,0,0,1 over cycles 0–3; display=0xA5 from cycle 1.
- OpIn=1, chaves=0x1234, confirma pulsed high for 10 cycles (DEBOUNCE=4) → aguardando_in=1 until CAPTURA; single EscreveIn pulse together with HabilitaPC=1; dado_in=0x0000_1234.
- confirma glitches high for 2 cycles during ESPERA_IN → no capture. Two back-to-back `in` with the button held → second capture only after release and re-press.
- OpHalt=1 together with OpIn=1 → PARADO; HabilitaPC=0 and parado=1 indefinitely. Then reset=0 for 1 cycle → EXECUTA, HabilitaPC=1.
- Reset asserted mid-MOSTRA and mid-ESPERA_IN → EXECUTA with display=0 and no EscreveIn pulse.
